sample_frame_assembler: RTL and testbench

SAMPLE_FRAME_ASSEMBLER -- requirements
Module: sample_frame_assembler

---
 rtl/sample_frame_assembler.sv | 147 ++++++++++++++
 tb/tb_sample_frame_assembler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_frame_assembler.sv
// sample_frame_assembler: packs big-endian SPI bytes into a frame of
// SAMPLES_NUM 16-bit samples. Each packet carries 2*SAMPLES_NUM data bytes
// followed by as many pad bytes. A completed frame is handed to the FIR
// stage with a one-cycle valid pulse, or dropped and counted as an overrun
// if the FIR stage is busy.
module sample_frame_assembler #(
    parameter int SAMPLES_NUM = 8
) (
    input  logic                      clkIn,
    input  logic                      resetIn,
    input  logic                      ssIn,
    input  logic [7:0]                byteIn,
    input  logic                      byteValidIn,
    input  logic                      busyIn,
    input  logic                      clearIn,
    output logic [16*SAMPLES_NUM-1:0] frameOut,
    output logic                      frameValidOut,
    output logic                      overrunOut,
    output logic [7:0]                overrunCountOut
);

    localparam int D  = 2 * SAMPLES_NUM;          // data bytes (= pad bytes) per packet
    localparam int FW = 8 * D;                    // frame width in bits
    localparam int CW = (D > 1) ? $clog2(D) : 1;  // byte counter width

    typedef enum logic {
        S_DATA,
        S_PAD
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]   shadow_q, shadow_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic            valid_q, valid_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      ovf_cnt_q, ovf_cnt_d;
    logic            last_byte;
    logic            overrun;
    logic [7:0]      ovf_cnt_base;

    // Next-state, byte placement and frame hand-off decisions.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        frame_d   = frame_q;
        valid_d   = 1'b0;
        overrun   = 1'b0;
        last_byte = (cnt_q == CW'(D - 1));

        if (ssIn) begin
            // Select released: abandon the packet, any strobed byte is dropped.
            state_d  = S_DATA;
            cnt_d    = '0;
            shadow_d = '0;
        end else if (byteValidIn) begin
            case (state_q)
                S_DATA: begin
                    // Byte k lands in the k-th byte lane counted from the MSB.
                    for (int k = 0; k < D; k++) begin
                        if (cnt_q == CW'(k)) begin
                            shadow_d[FW-1-8*k -: 8] = byteIn;
                        end
                    end
                    if (last_byte) begin
                        state_d = S_PAD;
                        cnt_d   = '0;
                        if (busyIn) begin
                            overrun = 1'b1;
                        end else begin
                            // Includes the byte being accepted this cycle.
                            frame_d = shadow_d;
                            valid_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_PAD: begin
                    if (last_byte) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Overrun status: a clear is applied first so a coincident overrun wins.
    always_comb begin
        ovf_cnt_base = clearIn ? 8'd0 : ovf_cnt_q;
        ovf_d        = clearIn ? 1'b0 : ovf_q;
        ovf_cnt_d    = ovf_cnt_base;
        if (overrun) begin
            ovf_d     = 1'b1;
            ovf_cnt_d = (ovf_cnt_base == 8'hFF) ? 8'hFF : ovf_cnt_base + 8'd1;
        end
    end

    // State register and shared byte counter.
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Shadow register, published frame and its valid pulse.
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            shadow_q <= '0;
            frame_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
            valid_q  <= valid_d;
        end
    end

    // Sticky overrun flag and saturating drop counter.
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= 8'd0;
        end else begin
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign frameOut        = frame_q;
    assign frameValidOut   = valid_q;
    assign overrunOut      = ovf_q;
    assign overrunCountOut = ovf_cnt_q;

endmodule

// File: tb/tb_sample_frame_assembler.sv
// Bench for sample_frame_assembler: a 2-sample instance covers the main
// packet, abort, overrun and reset behaviour; a 1-sample instance covers
// reset in the middle of a packet.
module tb_sample_frame_assembler;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 2-sample instance
    logic        rst2, ss2, bv2, busy2, clr2;
    logic [7:0]  byte2;
    logic [31:0] frame2;
    logic        fv2, ovf2;
    logic [7:0]  cnt2;

    // 1-sample instance
    logic        rst1, ss1, bv1, busy1, clr1;
    logic [7:0]  byte1;
    logic [15:0] frame1;
    logic        fv1, ovf1;
    logic [7:0]  cnt1;

    sample_frame_assembler #(.SAMPLES_NUM(2)) u_dut2 (
        .clkIn(clk), .resetIn(rst2), .ssIn(ss2), .byteIn(byte2),
        .byteValidIn(bv2), .busyIn(busy2), .clearIn(clr2),
        .frameOut(frame2), .frameValidOut(fv2), .overrunOut(ovf2),
        .overrunCountOut(cnt2)
    );

    sample_frame_assembler #(.SAMPLES_NUM(1)) u_dut1 (
        .clkIn(clk), .resetIn(rst1), .ssIn(ss1), .byteIn(byte1),
        .byteValidIn(bv1), .busyIn(busy1), .clearIn(clr1),
        .frameOut(frame1), .frameValidOut(fv1), .overrunOut(ovf1),
        .overrunCountOut(cnt1)
    );

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboards of frames expected to be published.
    logic [31:0] q2[$];
    logic [15:0] q1[$];
    logic [31:0] prev2, e2;
    logic [15:0] prev1, e1;

    // Monitor for the 2-sample instance.
    always @(negedge clk) begin
        if (rst2) begin
            prev2 = frame2;
        end else if (fv2) begin
            chk("pulse_expected2", 64'(q2.size() != 0), 64'd1);
            if (q2.size() != 0) begin
                e2 = q2.pop_front();
                chk("frame2", 64'(frame2), 64'(e2));
            end
            prev2 = frame2;
        end else begin
            chk("frame_hold2", 64'(frame2), 64'(prev2));
        end
    end

    // Monitor for the 1-sample instance.
    always @(negedge clk) begin
        if (rst1) begin
            prev1 = frame1;
        end else if (fv1) begin
            chk("pulse_expected1", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                chk("frame1", 64'(frame1), 64'(e1));
            end
            prev1 = frame1;
        end else begin
            chk("frame_hold1", 64'(frame1), 64'(prev1));
        end
    end

    task automatic put2(input logic [7:0] b);
        @(negedge clk);
        ss2 = 1'b0; bv2 = 1'b1; byte2 = b; busy2 = 1'b0; clr2 = 1'b0;
    endtask

    task automatic abort2();
        @(negedge clk);
        ss2 = 1'b1; bv2 = 1'b1; byte2 = 8'h99; busy2 = 1'b0;
    endtask

    // Four data bytes MSB first; busy/clear matter only on the last byte.
    task automatic send_data2(input logic [31:0] w, input logic busy,
                              input logic clr, input logic gaps);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ss2 = 1'b0; bv2 = 1'b1; byte2 = w[31-8*i -: 8];
            busy2 = (i == 3) ? busy : ~busy;
            clr2  = (i == 3) ? clr : 1'b0;
            if (gaps && i < 3) begin
                @(negedge clk);
                bv2 = 1'b0; byte2 = 8'hEE; busy2 = 1'b0;
            end
        end
        if (!busy) q2.push_back(w);
        @(negedge clk);
        bv2 = 1'b0; busy2 = 1'b0; clr2 = 1'b0;
        chk("vld_latency", 64'(fv2), 64'(!busy));
        @(negedge clk);
        chk("vld_one_cycle", 64'(fv2), 64'd0);
    endtask

    task automatic send_pad2(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ss2 = 1'b0; bv2 = 1'b1; byte2 = w[31-8*i -: 8];
            busy2 = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bv2 = 1'b0; busy2 = 1'b0;
    endtask

    task automatic put1(input logic [7:0] b);
        @(negedge clk);
        ss1 = 1'b0; bv1 = 1'b1; byte1 = b;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst2 = 1'b1; ss2 = 1'b1; bv2 = 1'b0; busy2 = 1'b0; clr2 = 1'b0; byte2 = 8'h00;
        rst1 = 1'b1; ss1 = 1'b1; bv1 = 1'b0; busy1 = 1'b0; clr1 = 1'b0; byte1 = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_frame", 64'(frame2), 64'd0);
        chk("rst_valid", 64'(fv2), 64'd0);
        chk("rst_ovf", 64'(ovf2), 64'd0);
        chk("rst_cnt", 64'(cnt2), 64'd0);
        rst2 = 1'b0; rst1 = 1'b0;
        @(negedge clk);

        // Basic packet, then pads, then the next packet.
        send_data2(32'h12345678, 1'b0, 1'b0, 1'b0);
        chk("frame_after_1", 64'(frame2), 64'h12345678);
        send_pad2(32'hAABBCCDD);
        chk("frame_after_pad", 64'(frame2), 64'h12345678);
        send_data2(32'h9ABCDEF0, 1'b0, 1'b0, 1'b0);
        send_pad2(32'h01020304);

        // Abort in the middle of data; the byte strobed with ss high is dropped.
        put2(8'h11); put2(8'h22); put2(8'h33);
        abort2();
        send_data2(32'h44556677, 1'b0, 1'b0, 1'b0);
        chk("frame_after_abort", 64'(frame2), 64'h44556677);
        chk("abort_no_ovf", 64'(ovf2), 64'd0);

        // Abort in the middle of the pad returns to data collection.
        put2(8'h5A); put2(8'hA5);
        abort2();
        send_data2(32'hCAFEF00D, 1'b0, 1'b0, 1'b0);
        send_pad2(32'h0BADBEEF);

        // Strobes with gaps: bytes with byteValidIn low are ignored.
        send_data2(32'hC0C1C2C3, 1'b0, 1'b0, 1'b1);
        send_pad2(32'h00000000);

        // Overrun then clear.
        send_data2(32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        chk("ovr_frame_kept", 64'(frame2), 64'hC0C1C2C3);
        chk("ovr_flag", 64'(ovf2), 64'd1);
        chk("ovr_cnt", 64'(cnt2), 64'd1);
        @(negedge clk); clr2 = 1'b1;
        @(negedge clk); clr2 = 1'b0;
        chk("clr_flag", 64'(ovf2), 64'd0);
        chk("clr_cnt", 64'(cnt2), 64'd0);
        send_pad2(32'h11111111);

        // Many overruns saturate the counter.
        for (int n = 0; n < 300; n++) begin
            send_data2($urandom, 1'b1, 1'b0, 1'b0);
            send_pad2($urandom);
        end
        chk("sat_cnt", 64'(cnt2), 64'd255);
        chk("sat_flag", 64'(ovf2), 64'd1);
        // Clear and overrun in the same cycle: the overrun wins.
        send_data2(32'h0F0F0F0F, 1'b1, 1'b1, 1'b0);
        chk("clr_ovr_cnt", 64'(cnt2), 64'd1);
        chk("clr_ovr_flag", 64'(ovf2), 64'd1);
        send_pad2(32'h22222222);

        // Packets stay aligned after the overrun storm.
        send_data2(32'h13572468, 1'b0, 1'b0, 1'b0);
        chk("frame_after_storm", 64'(frame2), 64'h13572468);

        // Asynchronous reset mid-packet.
        put2(8'hF1); put2(8'hF2);
        @(negedge clk); bv2 = 1'b0;
        #2 rst2 = 1'b1;
        #1;
        chk("async_rst_frame", 64'(frame2), 64'd0);
        chk("async_rst_ovf", 64'(ovf2), 64'd0);
        chk("async_rst_cnt", 64'(cnt2), 64'd0);
        @(negedge clk);
        @(negedge clk); rst2 = 1'b0;
        send_data2(32'h89ABCDEF, 1'b0, 1'b0, 1'b0);

        // 1-sample instance: reset after the first byte discards it.
        put1(8'hAB);
        @(negedge clk); bv1 = 1'b0;
        rst1 = 1'b1;
        @(negedge clk); rst1 = 1'b0;
        put1(8'hCD); put1(8'hEF);
        q1.push_back(16'hCDEF);
        @(negedge clk); bv1 = 1'b0;
        chk("s1_vld", 64'(fv1), 64'd1);
        @(negedge clk);
        chk("s1_one", 64'(fv1), 64'd0);
        chk("s1_frame", 64'(frame1), 64'hCDEF);
        put1(8'h77); put1(8'h88);
        put1(8'h12); put1(8'h34);
        q1.push_back(16'h1234);
        @(negedge clk); bv1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("s1_frame2", 64'(frame1), 64'h1234);

        repeat (3) @(negedge clk);
        chk("q2_drained", 64'(q2.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
